// File: rtl/wb_trace_buffer.sv
// -----------------------------------------------------------------------------
// wb_trace_buffer
//   Captures register write-back events from the pipeline into a circular FIFO
//   and drains them over a valid/ready handshake to a debug sink. Records that
//   arrive while the FIFO is full are dropped and counted.
//
//   Optional feature: define HILO_TRACE_EN to also trace changes of the HI/LO
//   registers as tagged records (tag 1 = HI, tag 2 = LO). Without the macro the
//   HI/LO inputs are ignored and OutTag is always 0.
//
// Parameters
//   DEPTH  FIFO entries (power of two, >= 2)
//   CNT_W  width of the saturating DropCount
// Ports
//   Clk, Reset       clock (rising edge), asynchronous active-low reset
//   WriteData        write-back data
//   ProgramCount     PC tagged to the write-back
//   RegWriteCommand  write-back valid this cycle (push request)
//   HIRegOutput      HI register value (HILO_TRACE_EN only)
//   LORegOutput      LO register value (HILO_TRACE_EN only)
//   OutReady         sink accepts the head record
//   OutValid         head record valid
//   OutPC/OutData    head record PC / data
//   OutTag           0 = GPR, 1 = HI change, 2 = LO change
//   Count            entries held
//   Overflow         sticky: a record was dropped since reset
//   DropCount        dropped records, saturating
// -----------------------------------------------------------------------------
module wb_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [31:0]              WriteData,
    input  logic [31:0]              ProgramCount,
    input  logic                     RegWriteCommand,
    input  logic [31:0]              HIRegOutput,
    input  logic [31:0]              LORegOutput,
    input  logic                     OutReady,
    output logic                     OutValid,
    output logic [31:0]              OutPC,
    output logic [31:0]              OutData,
    output logic [1:0]               OutTag,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow,
    output logic [CNT_W-1:0]         DropCount
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Storage and pointers
    logic [65:0]       mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              valid_q, valid_d;
    logic [65:0]       head_q, head_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    // Per-cycle control
    logic              pop_s;
    logic              full_s;
    logic              space_s;
    logic              gpr_push_s;
    logic              hi_push_s;
    logic              lo_push_s;
    logic              push_s;
    logic [65:0]       wdata_s;
    logic [1:0]        drop_inc_s;
    logic [CNT_W+1:0]  drop_sum_s;

    // HI/LO change tracking state (constant zero when the feature is off)
    logic              hi_chg_s, lo_chg_s;
    logic              hi_pend_q, lo_pend_q;
    logic [63:0]       hi_rec_q, lo_rec_q;

`ifdef HILO_TRACE_EN
    logic [31:0]       hi_shadow_q, lo_shadow_q;

    // Change detection against the previous-cycle register values
    always_comb begin
        hi_chg_s = (HIRegOutput != hi_shadow_q);
        lo_chg_s = (LORegOutput != lo_shadow_q);
    end

    // Shadow registers, pending flags and latched {PC,value} per register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hi_shadow_q <= 32'd0;
            lo_shadow_q <= 32'd0;
            hi_pend_q   <= 1'b0;
            lo_pend_q   <= 1'b0;
            hi_rec_q    <= 64'd0;
            lo_rec_q    <= 64'd0;
        end else begin
            hi_shadow_q <= HIRegOutput;
            lo_shadow_q <= LORegOutput;
            // A change in the same cycle as a push re-arms the flag with the new value
            hi_pend_q   <= hi_chg_s ? 1'b1 : (hi_push_s ? 1'b0 : hi_pend_q);
            lo_pend_q   <= lo_chg_s ? 1'b1 : (lo_push_s ? 1'b0 : lo_pend_q);
            hi_rec_q    <= hi_chg_s ? {ProgramCount, HIRegOutput} : hi_rec_q;
            lo_rec_q    <= lo_chg_s ? {ProgramCount, LORegOutput} : lo_rec_q;
        end
    end
`else
    logic unused_hilo_s;
    assign unused_hilo_s = ^{HIRegOutput, LORegOutput};
    assign hi_chg_s  = 1'b0;
    assign lo_chg_s  = 1'b0;
    assign hi_pend_q = 1'b0;
    assign lo_pend_q = 1'b0;
    assign hi_rec_q  = 64'd0;
    assign lo_rec_q  = 64'd0;
`endif

    // Push/pop arbitration, drop accounting and next-state computation
    always_comb begin
        pop_s      = valid_q && OutReady;
        full_s     = (count_q == CW'(DEPTH));
        space_s    = !full_s || pop_s;
        // Priority GPR > HI > LO; HI/LO only use otherwise idle cycles
        gpr_push_s = RegWriteCommand && space_s;
        hi_push_s  = !RegWriteCommand && hi_pend_q && space_s;
        lo_push_s  = !RegWriteCommand && !hi_pend_q && lo_pend_q && space_s;
        push_s     = gpr_push_s || hi_push_s || lo_push_s;

        if (gpr_push_s) begin
            wdata_s = {2'd0, ProgramCount, WriteData};
        end else if (hi_push_s) begin
            wdata_s = {2'd1, hi_rec_q};
        end else if (lo_push_s) begin
            wdata_s = {2'd2, lo_rec_q};
        end else begin
            wdata_s = 66'd0;
        end

        // GPR lost to a full FIFO, or a pending HI/LO overwritten before it could push
        drop_inc_s = {1'b0, RegWriteCommand && !space_s}
                   + {1'b0, hi_chg_s && hi_pend_q && !hi_push_s}
                   + {1'b0, lo_chg_s && lo_pend_q && !lo_push_s};
        drop_sum_s = {2'b00, drop_q} + (CNT_W+2)'(drop_inc_s);
        if (drop_sum_s > {2'b00, {CNT_W{1'b1}}}) begin
            drop_d = {CNT_W{1'b1}};
        end else begin
            drop_d = drop_sum_s[CNT_W-1:0];
        end
        ovf_d = ovf_q || (drop_inc_s != 2'd0);

        wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_s) - CW'(pop_s);
        valid_d  = (count_d != CW'(0));

        // Registered head: bypass the write when it lands in the new head slot
        if (push_s && (wr_ptr_q == rd_ptr_d)) begin
            head_d = wdata_s;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Storage array write, one slot per cycle
    always_ff @(posedge Clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wdata_s;
        end
    end

    // Pointers, occupancy, head register and overflow statistics
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= 66'd0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    assign OutValid  = valid_q;
    assign OutTag    = head_q[65:64];
    assign OutPC     = head_q[63:32];
    assign OutData   = head_q[31:0];
    assign Count     = count_q;
    assign Overflow  = ovf_q;
    assign DropCount = drop_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
module tb_wb_trace_buffer;

    localparam int DEPTH = 16;
    localparam int CNT_W = 4;
    localparam int DMAX  = (1 << CNT_W) - 1;

    logic        Clk;
    logic        Reset;
    logic [31:0] WriteData;
    logic [31:0] ProgramCount;
    logic        RegWriteCommand;
    logic [31:0] HIRegOutput;
    logic [31:0] LORegOutput;
    logic        OutReady;
    logic        OutValid;
    logic [31:0] OutPC;
    logic [31:0] OutData;
    logic [1:0]  OutTag;
    logic [4:0]  Count;
    logic        Overflow;
    logic [CNT_W-1:0] DropCount;

    int checks = 0;
    int errors = 0;

    wb_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .WriteData(WriteData), .ProgramCount(ProgramCount),
        .RegWriteCommand(RegWriteCommand), .HIRegOutput(HIRegOutput),
        .LORegOutput(LORegOutput), .OutReady(OutReady), .OutValid(OutValid),
        .OutPC(OutPC), .OutData(OutData), .OutTag(OutTag), .Count(Count),
        .Overflow(Overflow), .DropCount(DropCount)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Reference model: a queue of records plus drop statistics
    typedef struct {
        logic [1:0]  tag;
        logic [31:0] pc;
        logic [31:0] data;
    } rec_t;
    rec_t mq[$];
    int   m_drop;
    bit   m_ovf;

    typedef struct {
        logic        cmd;
        logic [31:0] pc;
        logic [31:0] data;
        logic        ready;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] edata;
        int          ecount;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("valid", 64'(OutValid), 64'(mq.size() != 0));
        chk("count", 64'(Count), 64'(mq.size()));
        chk("overflow", 64'(Overflow), 64'(m_ovf));
        chk("dropcount", 64'(DropCount), 64'(m_drop));
        if (mq.size() != 0) begin
            chk("head_pc", 64'(OutPC), 64'(mq[0].pc));
            chk("head_data", 64'(OutData), 64'(mq[0].data));
            chk("head_tag", 64'(OutTag), 64'(mq[0].tag));
        end
    endtask

    // One clock with currently driven inputs; model follows FIFO rules, then compare
    task automatic step();
        bit   pop;
        bit   full;
        rec_t r;
        pop  = (mq.size() != 0) && OutReady;
        full = (mq.size() == DEPTH);
        r.tag = 2'd0; r.pc = ProgramCount; r.data = WriteData;
        @(posedge Clk);
        if (pop) void'(mq.pop_front());
        if (RegWriteCommand) begin
            if (!full || pop) begin
                mq.push_back(r);
            end else begin
                m_ovf = 1'b1;
                if (m_drop < DMAX) m_drop++;
            end
        end
        #1;
        check_model();
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        RegWriteCommand = 1'b0;
        OutReady = 1'b0;
        HIRegOutput = 32'd0;
        LORegOutput = 32'd0;
        mq.delete();
        m_drop = 0;
        m_ovf = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_valid", 64'(OutValid), 64'd0);
        chk("rst_count", 64'(Count), 64'd0);
        chk("rst_pc", 64'(OutPC), 64'd0);
        chk("rst_data", 64'(OutData), 64'd0);
        chk("rst_tag", 64'(OutTag), 64'd0);
        chk("rst_ovf", 64'(Overflow), 64'd0);
        chk("rst_drop", 64'(DropCount), 64'd0);
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    vec_t vt[7];
    logic [31:0] s_pc, s_data;
    logic [1:0]  s_tag;

    initial begin
        WriteData = 32'd0;
        ProgramCount = 32'd0;
        vt[0] = '{1'b1, 32'h40, 32'h1234, 1'b1, 1'b1, 32'h40, 32'h1234, 1};
        vt[1] = '{1'b0, 32'h0,  32'h0,    1'b1, 1'b0, 32'h0,  32'h0,    0};
        vt[2] = '{1'b1, 32'h44, 32'hAAAA, 1'b0, 1'b1, 32'h44, 32'hAAAA, 1};
        vt[3] = '{1'b1, 32'h48, 32'hBBBB, 1'b0, 1'b1, 32'h44, 32'hAAAA, 2};
        vt[4] = '{1'b1, 32'h4C, 32'hCCCC, 1'b1, 1'b1, 32'h48, 32'hBBBB, 2};
        vt[5] = '{1'b0, 32'h0,  32'h0,    1'b1, 1'b1, 32'h4C, 32'hCCCC, 1};
        vt[6] = '{1'b0, 32'h0,  32'h0,    1'b1, 1'b0, 32'h0,  32'h0,    0};

        do_reset();

        // Table-driven basic push/pop/latency sequence
        for (int i = 0; i < 7; i++) begin
            RegWriteCommand = vt[i].cmd;
            ProgramCount    = vt[i].pc;
            WriteData       = vt[i].data;
            OutReady        = vt[i].ready;
            @(posedge Clk);
            #1;
            chk($sformatf("vec%0d_valid", i), 64'(OutValid), 64'(vt[i].ev));
            chk($sformatf("vec%0d_count", i), 64'(Count), 64'(vt[i].ecount));
            if (vt[i].ev) begin
                chk($sformatf("vec%0d_pc", i), 64'(OutPC), 64'(vt[i].epc));
                chk($sformatf("vec%0d_data", i), 64'(OutData), 64'(vt[i].edata));
            end
        end

        // Fill to full, overflow by one
        RegWriteCommand = 1'b1;
        OutReady = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            ProgramCount = 32'(i * 4);
            WriteData = 32'(i);
            step();
        end
        chk("full_count", 64'(Count), 64'd16);
        chk("full_no_ovf", 64'(Overflow), 64'd0);
        ProgramCount = 32'd68;
        WriteData = 32'd17;
        step();
        chk("ovf_set", 64'(Overflow), 64'd1);
        chk("ovf_drop1", 64'(DropCount), 64'd1);
        chk("ovf_count", 64'(Count), 64'd16);

        // Push and pop on the same edge while full
        ProgramCount = 32'h100;
        WriteData = 32'd100;
        OutReady = 1'b1;
        step();
        chk("pp_count", 64'(Count), 64'd16);
        chk("pp_drop", 64'(DropCount), 64'd1);

        // Drain in order across the pointer wrap
        RegWriteCommand = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("drain_order", 64'(OutData), (k < 15) ? 64'(k + 2) : 64'd100);
            step();
        end
        chk("drained", 64'(Count), 64'd0);

        // Stall with a valid head: outputs hold
        RegWriteCommand = 1'b1;
        ProgramCount = 32'hABC;
        WriteData = 32'h55;
        OutReady = 1'b0;
        step();
        RegWriteCommand = 1'b0;
        s_pc = OutPC; s_data = OutData; s_tag = OutTag;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_pc", 64'(OutPC), 64'(s_pc));
            chk("stall_data", 64'(OutData), 64'(s_data));
            chk("stall_tag", 64'(OutTag), 64'(s_tag));
        end
        OutReady = 1'b1;
        step();

        // Asynchronous reset mid-drain with five entries held
        RegWriteCommand = 1'b1;
        OutReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ProgramCount = 32'(32'h200 + i);
            WriteData = 32'(i + 50);
            step();
        end
        chk("pre_rst_count", 64'(Count), 64'd5);
        RegWriteCommand = 1'b0;
        OutReady = 1'b1;
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        chk("arst_valid", 64'(OutValid), 64'd0);
        chk("arst_count", 64'(Count), 64'd0);
        chk("arst_drop", 64'(DropCount), 64'd0);
        chk("arst_ovf", 64'(Overflow), 64'd0);
        mq.delete();
        m_drop = 0;
        m_ovf = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;

        // Randomized traffic: slow sink phase (drops, saturation) then fast sink phase
        for (int n = 0; n < 600; n++) begin
            RegWriteCommand = ($urandom_range(0, 9) < 7);
            ProgramCount = $urandom;
            WriteData = $urandom;
            OutReady = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step();
        end

        // HI change in the same cycle as a GPR push
        do_reset();
        RegWriteCommand = 1'b1;
        ProgramCount = 32'h300;
        WriteData = 32'h77;
        HIRegOutput = 32'd7;
        OutReady = 1'b0;
        @(posedge Clk);
        #1;
        chk("hl_gpr_first_tag", 64'(OutTag), 64'd0);
        chk("hl_gpr_first_data", 64'(OutData), 64'h77);
        RegWriteCommand = 1'b0;
        @(posedge Clk);
        #1;
`ifdef HILO_TRACE_EN
        chk("hl_count", 64'(Count), 64'd2);
`else
        chk("hl_count", 64'(Count), 64'd1);
`endif
        OutReady = 1'b1;
        @(posedge Clk);
        #1;
`ifdef HILO_TRACE_EN
        chk("hl_valid", 64'(OutValid), 64'd1);
        chk("hl_tag", 64'(OutTag), 64'd1);
        chk("hl_data", 64'(OutData), 64'd7);
        chk("hl_pc", 64'(OutPC), 64'h300);
`else
        chk("hl_valid", 64'(OutValid), 64'd0);
        chk("hl_count_end", 64'(Count), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
